// File: rtl/key_pkg.sv
// Shared definitions for the key event queue: event type codes, key FSM states
// and small helpers for building events and cleaning raw matrix codes.
package key_pkg;

    localparam int CODE_W = 6;
    localparam int EVT_W  = 8;

    typedef enum logic [1:0] {
        EVT_NONE    = 2'b00,
        EVT_PRESS   = 2'b01,
        EVT_RELEASE = 2'b10,
        EVT_REPEAT  = 2'b11
    } evt_type_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } key_state_t;

    function automatic logic [EVT_W-1:0] make_evt(input evt_type_t t, input logic [CODE_W-1:0] code);
        return {t, code};
    endfunction

    // A code with an empty row or column field cannot come from a real key.
    function automatic logic [CODE_W-1:0] normalise(input logic [CODE_W-1:0] raw);
        return (raw[2:0] == 3'd0 || raw[5:3] == 3'd0) ? '0 : raw;
    endfunction

endpackage

// File: rtl/key_evt_fifo.sv
// First-word-fall-through event FIFO; the head entry is presented while valid,
// pushes into a full FIFO are dropped unless a pop frees a slot in the same cycle.
module key_evt_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     CLK_LOW,
    input  logic                     RST_N,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop_req,
    output logic                     valid,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     drop
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [PTR_W:0]   count_reg, count_next;
    logic             full;
    logic             do_pop;
    logic             do_push;

    always_comb begin
        full        = (count_reg == FULL_CNT);
        do_pop      = pop_req && (count_reg != '0);
        do_push     = push && (!full || do_pop);
        drop        = push && full && !do_pop;
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (do_push) begin
            wr_ptr_next = wr_ptr_reg + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_next = rd_ptr_reg + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    // Storage carries no reset; the head is masked to zero while empty.
    always_ff @(posedge CLK_LOW) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge CLK_LOW) begin
        if (!RST_N) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    assign valid     = (count_reg != '0);
    assign head_data = valid ? mem[rd_ptr_reg] : '0;
    assign count     = count_reg;

endmodule

// File: rtl/key_event_queue.sv
// Keypad front end: debounces the raw matrix code, turns stable-code changes and
// long holds into press/release/repeat events and queues them for a consumer.
module key_event_queue
    import key_pkg::*;
#(
    parameter int DEB_CNT    = 4,
    parameter int HOLD_DLY   = 50,
    parameter int REPEAT_PER = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          CLK_LOW,
    input  logic                          RST_N,
    input  logic [5:0]                    KEY_VALUE,
    input  logic                          EVT_READY,
    input  logic                          OVF_CLR,
    output logic                          EVT_VALID,
    output logic [7:0]                    EVT_DATA,
    output logic [$clog2(FIFO_DEPTH):0]   EVT_CNT,
    output logic                          OVERFLOW
);

    localparam logic [7:0]  DEB_LAST  = 8'(DEB_CNT - 1);
    localparam logic [15:0] HOLD_LAST = 16'(HOLD_DLY - 1);
    localparam logic [15:0] REP_LAST  = 16'(REPEAT_PER - 1);

    logic [CODE_W-1:0] key_norm;
    logic [CODE_W-1:0] cand_reg, cand_next;
    logic [7:0]        deb_cnt_reg, deb_cnt_next;
    logic [CODE_W-1:0] stable_reg, stable_next;
    key_state_t        state_reg, state_next;
    logic [15:0]       timer_reg, timer_next;
    logic [15:0]       timer_last;
    logic              pend_reg, pend_next;
    logic [CODE_W-1:0] pend_code_reg, pend_code_next;
    logic              ovf_reg, ovf_next;

    logic              commit;
    logic              commit_push;
    logic [EVT_W-1:0]  commit_evt;
    logic              rpt_due;
    logic              push;
    logic [EVT_W-1:0]  push_data;
    logic              fifo_drop;

    always_comb begin
        key_norm       = normalise(KEY_VALUE);
        cand_next      = cand_reg;
        deb_cnt_next   = deb_cnt_reg;
        stable_next    = stable_reg;
        state_next     = state_reg;
        timer_next     = timer_reg;
        pend_next      = 1'b0;
        pend_code_next = pend_code_reg;
        commit_push    = 1'b0;
        commit_evt     = '0;
        rpt_due        = 1'b0;
        push           = 1'b0;
        push_data      = '0;
        timer_last     = (state_reg == ST_HOLD) ? HOLD_LAST : REP_LAST;

        if (key_norm == cand_reg) begin
            if (deb_cnt_reg != 8'hFF) begin
                deb_cnt_next = deb_cnt_reg + 1'b1;
            end
        end else begin
            cand_next    = key_norm;
            deb_cnt_next = '0;
        end

        commit = (deb_cnt_reg == DEB_LAST) && (cand_reg != stable_reg);

        case (state_reg)
            ST_IDLE: begin
                if (commit) begin
                    stable_next = cand_reg;
                    state_next  = ST_HOLD;
                    timer_next  = '0;
                    commit_push = 1'b1;
                    commit_evt  = make_evt(EVT_PRESS, cand_reg);
                end
            end
            ST_HOLD, ST_REPEAT: begin
                if (commit) begin
                    stable_next = cand_reg;
                    timer_next  = '0;
                    commit_push = 1'b1;
                    commit_evt  = make_evt(EVT_RELEASE, stable_reg);
                    if (cand_reg == '0) begin
                        state_next = ST_IDLE;
                    end else begin
                        // Key-to-key change: the press of the new key follows next cycle.
                        state_next     = ST_HOLD;
                        pend_next      = 1'b1;
                        pend_code_next = cand_reg;
                    end
                end else if (timer_reg == timer_last) begin
                    timer_next = '0;
                    state_next = ST_REPEAT;
                    rpt_due    = 1'b1;
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // One push per cycle: deferred press first, then commit, then repeat.
        if (pend_reg) begin
            push      = 1'b1;
            push_data = make_evt(EVT_PRESS, pend_code_reg);
        end else if (commit_push) begin
            push      = 1'b1;
            push_data = commit_evt;
        end else if (rpt_due) begin
            push      = 1'b1;
            push_data = make_evt(EVT_REPEAT, stable_reg);
        end

        if (fifo_drop) begin
            ovf_next = 1'b1;
        end else if (OVF_CLR) begin
            ovf_next = 1'b0;
        end else begin
            ovf_next = ovf_reg;
        end
    end

    always_ff @(posedge CLK_LOW) begin
        if (!RST_N) begin
            cand_reg      <= '0;
            deb_cnt_reg   <= '0;
            stable_reg    <= '0;
            state_reg     <= ST_IDLE;
            timer_reg     <= '0;
            pend_reg      <= 1'b0;
            pend_code_reg <= '0;
            ovf_reg       <= 1'b0;
        end else begin
            cand_reg      <= cand_next;
            deb_cnt_reg   <= deb_cnt_next;
            stable_reg    <= stable_next;
            state_reg     <= state_next;
            timer_reg     <= timer_next;
            pend_reg      <= pend_next;
            pend_code_reg <= pend_code_next;
            ovf_reg       <= ovf_next;
        end
    end

    key_evt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EVT_W)
    ) u_fifo (
        .CLK_LOW   (CLK_LOW),
        .RST_N     (RST_N),
        .push      (push),
        .push_data (push_data),
        .pop_req   (EVT_READY),
        .valid     (EVT_VALID),
        .head_data (EVT_DATA),
        .count     (EVT_CNT),
        .drop      (fifo_drop)
    );

    assign OVERFLOW = ovf_reg;

endmodule

// File: tb/tb_key_event_queue.sv
// Bench for key_event_queue: directed scenarios plus random key activity, every
// cycle compared against an event-level model (age arithmetic and a queue).
module tb_key_event_queue;

    localparam int DEB   = 4;
    localparam int HOLD  = 50;
    localparam int REP   = 10;
    localparam int DEPTH = 4;

    logic       CLK_LOW = 1'b0;
    logic       RST_N;
    logic [5:0] KEY_VALUE;
    logic       EVT_READY;
    logic       OVF_CLR;
    logic       EVT_VALID;
    logic [7:0] EVT_DATA;
    logic [2:0] EVT_CNT;
    logic       OVERFLOW;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model state
    logic [5:0] m_cand, m_stable, m_pend_code;
    int         m_cnt, m_age;
    bit         m_pend, m_ovf;
    logic [7:0] mq[$];

    // Statistics of events the DUT hands to the consumer
    int n_press, n_rep, n_rel, t_press, t_rep_first, t_rep_last, rep_gap_bad;

    key_event_queue #(
        .DEB_CNT    (DEB),
        .HOLD_DLY   (HOLD),
        .REPEAT_PER (REP),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .CLK_LOW   (CLK_LOW),
        .RST_N     (RST_N),
        .KEY_VALUE (KEY_VALUE),
        .EVT_READY (EVT_READY),
        .OVF_CLR   (OVF_CLR),
        .EVT_VALID (EVT_VALID),
        .EVT_DATA  (EVT_DATA),
        .EVT_CNT   (EVT_CNT),
        .OVERFLOW  (OVERFLOW)
    );

    always #5 CLK_LOW = ~CLK_LOW;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic void m_reset();
        m_cand = '0; m_stable = '0; m_pend_code = '0;
        m_cnt = 0; m_age = 0; m_pend = 0; m_ovf = 0;
        mq.delete();
    endfunction

    function automatic void stats_clear();
        n_press = 0; n_rep = 0; n_rel = 0;
        t_press = 0; t_rep_first = 0; t_rep_last = 0; rep_gap_bad = 0;
    endfunction

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        logic [5:0] norm;
        logic [7:0] pv;
        bit pop, have, commit, drop;
        if (!RST_N) begin
            m_reset();
            return;
        end
        norm = (KEY_VALUE[2:0] == 3'd0 || KEY_VALUE[5:3] == 3'd0) ? 6'd0 : KEY_VALUE;
        pop  = EVT_READY && (mq.size() > 0);
        have = 0;
        pv   = '0;
        if (m_pend) begin
            have = 1; pv = {2'b01, m_pend_code}; m_pend = 0;
        end
        commit = (m_cnt == DEB - 1) && (m_cand != m_stable);
        if (commit) begin
            if (m_stable == 6'd0) begin
                if (!have) begin have = 1; pv = {2'b01, m_cand}; end
            end else begin
                if (!have) begin have = 1; pv = {2'b10, m_stable}; end
                if (m_cand != 6'd0) begin m_pend = 1; m_pend_code = m_cand; end
            end
            m_stable = m_cand;
            m_age    = 0;
        end else if (m_stable != 6'd0) begin
            m_age++;
            if ((m_age == HOLD || (m_age > HOLD && (m_age - HOLD) % REP == 0)) && !have) begin
                have = 1; pv = {2'b11, m_stable};
            end
        end
        if (norm == m_cand) begin
            if (m_cnt < 255) m_cnt++;
        end else begin
            m_cand = norm; m_cnt = 0;
        end
        if (pop) void'(mq.pop_front());
        drop = have && (mq.size() >= DEPTH);
        if (have && !drop) mq.push_back(pv);
        if (drop) m_ovf = 1;
        else if (OVF_CLR) m_ovf = 0;
    endtask

    task automatic cycle();
        check("valid", EVT_VALID, 32'(mq.size() > 0));
        check("data", EVT_DATA, (mq.size() > 0) ? 32'(mq[0]) : 32'h0);
        check("cnt", EVT_CNT, 32'(mq.size()));
        check("ovf", OVERFLOW, 32'(m_ovf));
        if (EVT_VALID && EVT_READY) begin
            $display("evt cyc=%0d data=%02h cnt=%0d", cyc, EVT_DATA, EVT_CNT);
            case (EVT_DATA[7:6])
                2'b01: begin n_press++; t_press = cyc; end
                2'b10: n_rel++;
                2'b11: begin
                    if (n_rep == 0) t_rep_first = cyc;
                    else if (cyc - t_rep_last != REP) rep_gap_bad++;
                    t_rep_last = cyc;
                    n_rep++;
                end
                default: ;
            endcase
        end
        model_step();
        @(posedge CLK_LOW);
        #1;
        cyc++;
    endtask

    task automatic drive(input logic [5:0] kv, input int n, input logic rdy, input logic clr);
        for (int i = 0; i < n; i++) begin
            KEY_VALUE = kv;
            EVT_READY = rdy;
            OVF_CLR   = clr;
            cycle();
        end
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        drive(6'd0, 2, 1'b0, 1'b0);
        RST_N = 1'b1;
    endtask

    initial begin
        RST_N = 1'b0; KEY_VALUE = '0; EVT_READY = 1'b0; OVF_CLR = 1'b0;
        stats_clear();
        repeat (2) @(posedge CLK_LOW);
        #1;
        m_reset();
        RST_N = 1'b1;
        check("rst_valid", EVT_VALID, 0);
        check("rst_data", EVT_DATA, 0);
        check("rst_cnt", EVT_CNT, 0);
        check("rst_ovf", OVERFLOW, 0);

        // Too-short press produces nothing
        drive(6'o11, 3, 1'b0, 1'b0);
        drive(6'o00, 8, 1'b0, 1'b0);
        check("short_cnt", EVT_CNT, 0);

        // Press/release latency and encodings
        do_reset();
        drive(6'o11, 4, 1'b0, 1'b0);
        check("commit_lat", EVT_VALID, 0);
        drive(6'o00, 1, 1'b0, 1'b0);
        check("press_vis", EVT_VALID, 1);
        check("press_data", EVT_DATA, 8'h49);
        drive(6'o00, 4, 1'b0, 1'b0);
        check("rel_cnt", EVT_CNT, 2);
        drive(6'o00, 1, 1'b1, 1'b0);
        check("rel_data", EVT_DATA, 8'h89);
        drive(6'o00, 2, 1'b1, 1'b0);

        // Long hold: press then repeats on schedule
        do_reset();
        drive(6'o00, 4, 1'b1, 1'b0);
        stats_clear();
        drive(6'o23, 200, 1'b1, 1'b0);
        drive(6'o00, 10, 1'b1, 1'b0);
        check("hold_press", n_press, 1);
        check("hold_rep", n_rep, 15);
        check("hold_total", n_press + n_rep, 16);
        check("hold_rel", n_rel, 1);
        check("first_rep_gap", t_rep_first - t_press, HOLD);
        check("rep_gap_bad", rep_gap_bad, 0);

        // Direct key change
        do_reset();
        drive(6'o11, 6, 1'b0, 1'b0);
        drive(6'o23, 8, 1'b0, 1'b0);
        check("chg_cnt", EVT_CNT, 3);
        check("chg_0", EVT_DATA, 8'h49);
        drive(6'o23, 1, 1'b1, 1'b0);
        check("chg_1", EVT_DATA, 8'h89);
        drive(6'o23, 1, 1'b1, 1'b0);
        check("chg_2", EVT_DATA, 8'h53);
        drive(6'o23, 1, 1'b1, 1'b0);
        drive(6'o00, 8, 1'b1, 1'b0);

        // Overflow with stalled consumer
        do_reset();
        drive(6'o11, 6, 1'b0, 1'b0);
        drive(6'o00, 6, 1'b0, 1'b0);
        drive(6'o23, 6, 1'b0, 1'b0);
        drive(6'o00, 6, 1'b0, 1'b0);
        drive(6'o11, 6, 1'b0, 1'b0);
        drive(6'o00, 6, 1'b0, 1'b0);
        check("ovf_cnt", EVT_CNT, 4);
        check("ovf_flag", OVERFLOW, 1);
        check("ovf_q0", EVT_DATA, 8'h49);
        drive(6'o00, 1, 1'b1, 1'b0);
        check("ovf_q1", EVT_DATA, 8'h89);
        drive(6'o00, 1, 1'b1, 1'b0);
        check("ovf_q2", EVT_DATA, 8'h53);
        drive(6'o00, 1, 1'b1, 1'b0);
        check("ovf_q3", EVT_DATA, 8'h93);
        drive(6'o00, 1, 1'b1, 1'b0);
        check("ovf_empty", EVT_CNT, 0);
        drive(6'o00, 1, 1'b0, 1'b1);
        check("ovf_clr", OVERFLOW, 0);

        // Reset while repeating
        do_reset();
        drive(6'o00, 2, 1'b1, 1'b0);
        drive(6'o23, 70, 1'b1, 1'b0);
        RST_N = 1'b0;
        drive(6'o23, 1, 1'b1, 1'b0);
        RST_N = 1'b1;
        check("mid_rst_valid", EVT_VALID, 0);
        check("mid_rst_data", EVT_DATA, 0);
        check("mid_rst_cnt", EVT_CNT, 0);
        check("mid_rst_ovf", OVERFLOW, 0);
        drive(6'o23, 4, 1'b1, 1'b0);
        check("no_release", EVT_VALID, 0);
        drive(6'o23, 1, 1'b1, 1'b0);
        check("repress_valid", EVT_VALID, 1);
        check("repress_data", EVT_DATA, 8'h53);
        drive(6'o00, 8, 1'b1, 1'b0);

        // Random key activity
        for (int s = 0; s < 300; s++) begin
            int r;
            int len;
            logic [5:0] kv;
            r = $urandom_range(0, 99);
            if (r < 25) kv = 6'd0;
            else if (r < 35) kv = 6'($urandom_range(0, 7)) << 3;
            else kv = {3'($urandom_range(1, 7)), 3'($urandom_range(1, 7))};
            len = ($urandom_range(0, 9) == 0) ? $urandom_range(40, 90) : $urandom_range(1, 8);
            if ($urandom_range(0, 199) == 0) begin
                RST_N = 1'b0;
                drive(kv, 1, 1'b1, 1'b0);
                RST_N = 1'b1;
            end
            for (int i = 0; i < len; i++) begin
                drive(kv, 1, $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 4);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/key_event_queue.md
KEY_EVENT_QUEUE -- requirements
Module: key_event_queue

Interface
REQ-001 Parameter DEB_CNT, default 4, number of consecutive identical samples required to accept a key code (range 2..255).
REQ-002 Parameter HOLD_DLY, default 50, cycles a key must stay stable-pressed before the first repeat event (range 2..65535).
REQ-003 Parameter REPEAT_PER, default 10, cycles between successive repeat events (range 2..65535).
REQ-004 Parameter FIFO_DEPTH, default 4, number of event entries, power of two.
REQ-005 CLK_LOW  input  1  sole clock; all logic on rising edge.
REQ-006 RST_N  input  1  reset, synchronous and active-low.
REQ-007 KEY_VALUE  input  6  raw matrix code from the row/column decoder, {col[2:0], row[2:0]}, 0 = no key.
REQ-008 EVT_READY  input  1  consumer accepts the head event.
REQ-009 OVF_CLR  input  1  clears OVERFLOW.
REQ-010 EVT_VALID  output  1  FIFO not empty.
REQ-011 EVT_DATA  output  8  head event, {type[1:0], code[5:0]}; type 01 press, 10 release, 11 repeat.
REQ-012 EVT_CNT  output  log2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-013 OVERFLOW  output  1  sticky flag: at least one event dropped.

Function
REQ-014 Normalisation: a KEY_VALUE with row field 0 or column field 0 SHALL be treated as 0 (no key).
REQ-015 Debounce: the block keeps a candidate code and a sample counter; a normalised input equal to the candidate increments the counter (saturating); a different input loads the candidate and clears the counter.
REQ-016 Commit: when the counter reaches DEB_CNT-1 and the candidate differs from the stable code, the stable code SHALL take the candidate value in that cycle.
REQ-017 Commit 0->K SHALL push press(K); commit K->0 SHALL push release(K); commit A->B SHALL push release(A) in the commit cycle and press(B) exactly one cycle later.
REQ-018 Key FSM states: IDLE (stable = 0), HOLD (pressed, counting HOLD_DLY), REPEAT (counting REPEAT_PER).
REQ-019 IDLE->HOLD on a press commit; HOLD->REPEAT, pushing repeat(K), when the hold counter reaches HOLD_DLY-1; REPEAT pushes repeat(K) and restarts its counter every REPEAT_PER cycles.
REQ-020 Any release commit SHALL return the FSM to IDLE from HOLD or REPEAT; an A->B commit SHALL re-enter HOLD with a cleared counter.
REQ-021 At most one push per cycle; a repeat due in the same cycle as the deferred press(B) SHALL be discarded.
REQ-022 FIFO is first-word-fall-through: EVT_DATA is valid in the same cycle as EVT_VALID; pop occurs when EVT_VALID and EVT_READY are both high.
REQ-023 Push latency: a pushed event SHALL be visible on EVT_VALID/EVT_DATA in the cycle after the push.
REQ-024 Full FIFO: a push without a simultaneous pop SHALL be dropped and SHALL set OVERFLOW; a push with a simultaneous pop SHALL be accepted.
REQ-025 Empty FIFO: EVT_READY SHALL have no effect and the pointers SHALL not move.
REQ-026 Pointers SHALL wrap modulo FIFO_DEPTH; EVT_CNT SHALL equal pushes minus pops at all times.
REQ-027 OVERFLOW SHALL be cleared by OVF_CLR; when OVF_CLR and a dropped push coincide, OVERFLOW SHALL remain set.

Reset
REQ-028 When RST_N is low at a clock edge: EVT_VALID=0, EVT_DATA=0, EVT_CNT=0, OVERFLOW=0, FSM=IDLE, stable/candidate/counters=0, deferred press cleared.
REQ-029 Reset mid-press SHALL emit no release event; a key still held after reset SHALL produce press after DEB_CNT samples.

Structure
REQ-030 Event type encodings and the FSM state encoding SHALL reside in a shared package, key_pkg.
REQ-031 The FIFO SHALL be a sub-module, key_evt_fifo, parameterised by depth and width.

Verification
REQ-032 KEY_VALUE 0 -> 6'o11 held 3 cycles then 0 -> no event is pushed.
REQ-033 6'o11 held 4 cycles -> EVT_DATA 8'h49 (press) is visible in the cycle after the commit cycle; release to 0 for 4 cycles -> 8'h89.
REQ-034 6'o23 held 200 cycles with defaults -> press, a repeat (8'hD3) 50 cycles after the commit, then one repeat every 10 cycles, 16 events in total.
REQ-035 Direct change 6'o11 -> 6'o23 -> release 8'h89 and press 8'h53 are pushed on consecutive cycles.
REQ-036 EVT_READY=0 with 6 events generated -> EVT_CNT=4, OVERFLOW=1, the first four events are preserved in order; OVF_CLR -> OVERFLOW=0.
REQ-037 RST_N pulled low during REPEAT -> all outputs return to their reset values next cycle and no release event is generated.
